// File: rtl/sumsq_unit_if.sv
// Handshake and data bundle between a requester and the sum-of-squares stage.
// Carries operands, request, saturated result, overflow flag, ack pulse and busy.
// master drives the request side; slave (the stage) drives the result side.
interface sumsq_unit_if #(
    parameter int IN_W  = 4,
    parameter int OUT_W = 8
);
    logic             start;
    logic [IN_W-1:0]  X;
    logic [IN_W-1:0]  Y;
    logic [OUT_W-1:0] A;
    logic             ovf;
    logic             ack;
    logic             busy;

    modport master (
        output start, X, Y,
        input  A, ovf, ack, busy
    );

    modport slave (
        input  start, X, Y,
        output A, ovf, ack, busy
    );
endinterface

// File: rtl/sumsq_unit.sv
// Iterative X*X + Y*Y with shift-add multiply, saturated to OUT_W bits for the root unit.
// Latency: ack at edge k+2*IN_W+1 after acceptance at edge k; busy from k until k+2*IN_W+2.
// No backpressure: start is only sampled in IDLE, and is ignored while busy.
module sumsq_unit #(
    parameter int IN_W  = 4,
    parameter int OUT_W = 8
) (
    input  logic         Clk,
    input  logic         Rst,
    sumsq_unit_if.slave  bus
);
    // Accumulator is one bit wider than a single square, so the sum of two never wraps.
    localparam int ACC_W = 2 * IN_W + 1;
    localparam int CNT_W = (IN_W > 1) ? $clog2(IN_W) : 1;
    localparam logic [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** OUT_W) - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IN_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        MULX,
        MULY,
        SUM,
        DONE
    } state_t;

    state_t           state;
    logic [IN_W-1:0]  xcopy;
    logic [IN_W-1:0]  ycopy;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;

    logic [IN_W-1:0]  cur_op;
    logic             cur_bit;
    logic [ACC_W-1:0] addend;

    // Partial product for the current multiplier bit: operand squared one bit at a time.
    always_comb begin
        cur_op  = (state == MULY) ? ycopy : xcopy;
        cur_bit = |(cur_op & (IN_W'(1) << cnt));
        addend  = cur_bit ? (ACC_W'(cur_op) << cnt) : '0;
    end

    // Control FSM with datapath and registered outputs; reset discards any work in flight.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state    <= IDLE;
            xcopy    <= '0;
            ycopy    <= '0;
            acc      <= '0;
            cnt      <= '0;
            bus.A    <= '0;
            bus.ovf  <= 1'b0;
            bus.ack  <= 1'b0;
            bus.busy <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        xcopy    <= bus.X;
                        ycopy    <= bus.Y;
                        acc      <= '0;
                        cnt      <= '0;
                        bus.busy <= 1'b1;
                        state    <= MULX;
                    end
                end
                MULX: begin
                    acc <= acc + addend;
                    if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        state <= MULY;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                MULY: begin
                    acc <= acc + addend;
                    if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        state <= SUM;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SUM: begin
                    if (acc > SAT_MAX) begin
                        bus.A   <= '1;
                        bus.ovf <= 1'b1;
                    end else begin
                        bus.A   <= acc[OUT_W-1:0];
                        bus.ovf <= 1'b0;
                    end
                    bus.ack <= 1'b1;
                    state   <= DONE;
                end
                DONE: begin
                    bus.ack  <= 1'b0;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state    <= IDLE;
                    bus.ack  <= 1'b0;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/sumsq_unit.md
Name: sumsq_unit

Overview:
- Iterative sum-of-squares stage that sits directly upstream of the integer square-root unit.
- Takes two unsigned operands, computes X*X + Y*Y with a shift-add multiplier, saturates the sum to the root unit's 8-bit radicand width, and presents it on A with a one-cycle ack pulse.
- Together with the square-root unit it forms a vector-magnitude path, sqrt(X^2+Y^2).

Parameters:
IN_W, 4, operand width in bits (unsigned).
OUT_W, 8, result width in bits; must be no greater than 2*IN_W+1; the sum saturates to 2^OUT_W-1.

Ports:
Clk  input  1  system clock; all state updates on its rising edge.
Rst  input  1  asynchronous, active-high reset.
start  input  1  request; sampled only in IDLE.
X  input  IN_W  first operand, latched on accepted start.
Y  input  IN_W  second operand, latched on accepted start.
A  output  OUT_W  saturated X*X+Y*Y; feeds the square-root unit's radicand.
ovf  output  1  high when the true sum exceeded 2^OUT_W-1; valid with A.
ack  output  1  one-cycle pulse; A and ovf are valid from this cycle onward.
busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (Rst=1, asynchronous): state=IDLE; A=0, ovf=0, ack=0, busy=0; internal accumulator, operand copies and bit counter all 0. This applies at any time, mid-operation included. Pending work is discarded and no ack is issued.
- State machine: IDLE, MULX, MULY, SUM, DONE. All outputs are registered.
- IDLE: at the edge where start=1 (edge k), latch X and Y, clear the accumulator and counter, and go to MULX. With start=0, stay in IDLE. A and ovf keep their last values.
- MULX: one shift-add step per edge. If bit cnt of Xcopy is 1, add Xcopy<<cnt into a 2*IN_W+1-bit accumulator. After IN_W steps (edges k+1..k+IN_W), clear cnt and go to MULY.
- MULY: same procedure on Ycopy, adding into the same accumulator, at edges k+IN_W+1..k+2*IN_W. Then go to SUM.
- SUM, edge k+2*IN_W+1:
  - If acc > 2^OUT_W-1: A = all ones, ovf=1.
  - Otherwise: A = acc[OUT_W-1:0], ovf=0.
  - ack<=1, go to DONE.
- DONE, next edge: ack<=0, go to IDLE.
- Defaults (IN_W=4): ack is high for exactly one cycle, between edges k+9 and k+10. A is valid from edge k+9. Minimum start-to-start spacing is 11 cycles. With start held high continuously, the next acceptance occurs at edge k+11.
- start while busy=1 is ignored entirely: no latch, no queue. Changes on X and Y after acceptance have no effect on the result.
- Accumulator width is 2*IN_W+1, so no wrap is possible; the maximum is 2*(2^IN_W-1)^2 (450 at the defaults).
- A and ovf are held stable from ack until the next SUM, so the downstream unit may sample them at any time after ack.

Test Plan:
1. Reset, then start at edge k with X=3, Y=4 -> busy=1 from k. At edge k+9: A=25, ovf=0, ack=1 for exactly one cycle. busy=0 after k+10.
2. X=15, Y=5 -> A=250, ovf=0. Then X=15, Y=6 -> A=255, ovf=1 (true sum 261). Then X=15, Y=15 -> A=255, ovf=1 (true sum 450).
3. X=0, Y=0 -> A=0, ovf=0, ack still pulses at k+9. Then X=11, Y=7 -> A=170.
4. Accept X=12, Y=9. At k+3, pulse start with X=1, Y=1 and also change the X/Y inputs -> single ack at k+9 with A=225. No second ack follows.
5. Accept X=9, Y=9. Assert Rst at k+5 (between edges) -> A, ack, busy and ovf go 0 immediately without waiting for a clock, and no ack follows. After release, X=2, Y=2 -> A=8.
6. Hold start=1 with X=5, Y=12 continuously -> acks at k+9, k+20, k+31, each with A=169, ovf=0.
